// File: rtl/demux_1to8_seq.sv
// Sequential 1-to-8 demultiplexer: assembles a serial bit stream into bytes
// using a 3-bit slot counter, and presents each finished byte on a holding
// register with a valid/ready handshake and a sticky overrun flag.
module demux_1to8_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_din,
    input  logic       i_din_valid,
    input  logic       i_start,
    output logic [7:0] o_dout,
    output logic       o_dout_valid,
    input  logic       i_dout_ready,
    output logic [2:0] o_sel,
    output logic       o_busy,
    output logic       o_overrun
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e     r_state;
    logic [2:0] r_sel;
    logic [7:0] r_slot;
    logic [7:0] r_dout;
    logic       r_dout_valid;
    logic       r_overrun;

    logic [2:0] w_pos;
    logic [7:0] w_slot_merged;
    logic [7:0] w_slot_first;
    logic       w_complete;
    logic       w_free;
    logic       w_load;
    logic       w_drop;
    logic       w_consume;

    // Bit position of the current slot and the slot register with this bit merged in
    always_comb begin
        w_pos                = MSB_FIRST ? (3'd7 - r_sel) : r_sel;
        w_slot_merged        = r_slot;
        w_slot_merged[w_pos] = i_din;
        // On start, the accompanying bit (if any) becomes slot 0 of a fresh frame
        w_slot_first         = MSB_FIRST ? {i_din, 7'b0} : {7'b0, i_din};
    end

    // Frame completion and holding-register handshake decisions
    always_comb begin
        // A completion coinciding with start is cancelled
        w_complete = i_din_valid && !i_start && (r_sel == 3'd7);
        w_free     = !r_dout_valid || i_dout_ready;
        w_load     = w_complete && w_free;
        w_drop     = w_complete && !w_free;
        w_consume  = r_dout_valid && i_dout_ready;
    end

    // Single FSM block: slot collection, holding register and overrun flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_sel        <= 3'd0;
            r_slot       <= 8'h00;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (i_start) begin
                if (i_din_valid) begin
                    r_slot  <= w_slot_first;
                    r_sel   <= 3'd1;
                    r_state <= StCollect;
                end else begin
                    r_slot  <= 8'h00;
                    r_sel   <= 3'd0;
                    r_state <= StIdle;
                end
            end else if (i_din_valid) begin
                case (r_state)
                    StIdle: begin
                        r_slot  <= w_slot_merged;
                        r_sel   <= 3'd1;
                        r_state <= StCollect;
                    end
                    StCollect: begin
                        if (r_sel == 3'd7) begin
                            r_slot  <= 8'h00;
                            r_sel   <= 3'd0;
                            r_state <= StIdle;
                        end else begin
                            r_slot  <= w_slot_merged;
                            r_sel   <= r_sel + 3'd1;
                            r_state <= StCollect;
                        end
                    end
                    default: begin
                        r_slot  <= 8'h00;
                        r_sel   <= 3'd0;
                        r_state <= StIdle;
                    end
                endcase
            end

            if (w_load) begin
                r_dout <= w_slot_merged;
            end

            if (w_load) begin
                r_dout_valid <= 1'b1;
            end else if (w_consume) begin
                r_dout_valid <= 1'b0;
            end

            // Set wins over the start-driven clear
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_start) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_sel        = r_sel;
    assign o_busy       = (r_state == StCollect);
    assign o_overrun    = r_overrun;

endmodule
